apb_slave_regfile: RTL and testbench
====================================

// Module: apb_slave_regfile
// PURPOSE
//  APB slave register file. Sits directly downstream of the APB master on the psel/penable/paddr/pwrite/pwdata bus.
//  Holds DEPTH 32-bit registers.
//  Adds a programmable number of wait states to every transfer.
//  Signals pslverr on misaligned or out-of-range accesses.
// PARAMETERS
//  ADDR_W       32  width of paddr consumed (master's paddr[31:0]; paddr[32] is decoded into psel upstream)
//  DEPTH        16  number of 32-bit registers; word index = paddr[ADDR_W-1:2]
//  WAIT_STATES   1  extra pready-low cycles per access, 0..15
//  WPROT_LIMIT   4  registers with index < WPROT_LIMIT are write-protected (used only with APB_SLV_WPROT_EN)
// PORTS
//  pclk     in   1       clock; all logic on rising edge
//  preset   in   1       synchronous reset, active-high
//  psel     in   1       slave select
//  penable  in   1       access phase
//  pwrite   in   1       1 = write, 0 = read
//  paddr    in   ADDR_W  byte address
//  pwdata   in   32      write data
//  prdata   out  32      read data; valid while pready = 1
//  pready   out  1       transfer complete
//  pslverr  out  1       error response; valid while pready = 1
// BEHAVIOUR
//  - Reset (preset = 1 at an edge):
//    - state <= IDLE, pready = 0, pslverr = 0, prdata = 0.
//    - All DEPTH registers are cleared to 0.
//    - Any pending transfer is dropped with no write.
//  - FSM states: IDLE, WAIT, READY. All outputs are registered.
//  - IDLE
//    - On psel = 1 & penable = 0 (setup cycle), latch paddr, pwrite and pwdata.
//    - Set cnt <= WAIT_STATES and go to WAIT.
//    - psel & penable seen in IDLE (no setup cycle) is ignored and the state stays IDLE.
//  - WAIT
//    - Requires psel = 1 & penable = 1. If psel drops, abort to IDLE with no write.
//    - cnt > 0: cnt <= cnt - 1.
//    - cnt == 0: go to READY with pready <= 1, pslverr <= err, prdata <= (read & !err) ? reg[idx] : 0.
//  - READY
//    - pready is high for exactly one cycle.
//    - A write commits at this edge only if !err and psel & penable are still high.
//    - Next state is IDLE. pready, pslverr and prdata return to 0 next cycle.
//    - The master's next setup cycle is therefore seen in IDLE.
//  - Latency: with setup at cycle 0, pready is high at cycle WAIT_STATES + 2.
//  - err = misaligned (paddr[1:0] != 0) OR idx >= DEPTH. No register changes on err.
//  - Write-only-upper-bits: paddr bits above the index range must be 0, otherwise out-of-range.
//  - cnt is 4 bits and saturates at 0. Address and data are latched in the setup cycle.
//    Changes on paddr or pwdata during the access phase are ignored.
//  - Read of a register written in the immediately preceding transfer returns the new value.
// CONFIGURATION
//  - APB_SLV_WPROT_EN defined:
//    - A write to idx < WPROT_LIMIT sets err: pslverr = 1 and the register is unchanged.
//    - Reads of those registers are normal.
//  - APB_SLV_WPROT_EN undefined: all registers are writable and WPROT_LIMIT is unused.
// TESTING
//  1 Reset: preset = 1 for 2 cycles -> pready = 0, pslverr = 0, prdata = 0. Read idx 5 afterwards returns 0.
//  2 Write 0xDEADBEEF to 0x14, then read 0x14 (WAIT_STATES = 1)
//    -> pready high at cycle 3 of each transfer, read prdata = 0xDEADBEEF, pslverr = 0.
//  3 Read 0x13 (misaligned) and write to 0x40 (idx 16 >= DEPTH) -> pslverr = 1 with pready, prdata = 0, no register change.
//  4 psel dropped during WAIT of a write to 0x08 -> FSM returns to IDLE, reg[2] unchanged, pready stays 0.
//  5 preset asserted in WAIT of a write -> all outputs 0 next cycle, write discarded, next transfer works normally.
//  6 With APB_SLV_WPROT_EN: write 0x1234 to 0x04 -> pslverr = 1 and read-back = 0.
//    Without the macro: pslverr = 0 and read-back = 0x1234.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
//   APB slave holding DEPTH 32-bit registers. Every transfer is stretched by
//   WAIT_STATES extra pready-low cycles. pslverr is raised for misaligned
//   addresses and for word indices >= DEPTH. Any address bit above the index
//   range also makes the index >= DEPTH.
//
//   Optional feature (macro APB_SLV_WPROT_EN): registers with index below
//   WPROT_LIMIT reject writes with pslverr. Reads of those registers are normal.
//
// Ports
//   pclk     clock, rising edge
//   preset   synchronous reset, active high
//   psel     slave select
//   penable  access phase
//   pwrite   1 = write, 0 = read
//   paddr    byte address (ADDR_W bits)
//   pwdata   write data
//   prdata   read data, valid while pready = 1
//   pready   transfer complete, high for one cycle
//   pslverr  error response, valid while pready = 1
module apb_slave_regfile #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1,
  parameter int WPROT_LIMIT = 4
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr
);

`ifdef APB_SLV_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  // Request captured in the setup cycle. Access-phase bus values are ignored.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [31:0]       wdata;
  } req_t;

  state_t                 state;
  req_t                   req;
  logic [3:0]             cnt;
  logic [DEPTH-1:0][31:0] regs;

  logic [ADDR_W-3:0] idx;
  logic [IDX_W-1:0]  ridx;
  logic              mis, oor, wprot, err;

  assign idx   = req.addr[ADDR_W-1:2];
  assign ridx  = req.addr[IDX_W+1:2];
  assign mis   = req.addr[1:0] != 2'b00;
  assign oor   = idx >= (ADDR_W-2)'(DEPTH);
  // The WPROT_EN gate keeps the term present in every build. When the
  // feature is off, the term is constant zero.
  assign wprot = WPROT_EN && req.write && (idx < (ADDR_W-2)'(WPROT_LIMIT));
  assign err   = mis | oor | wprot;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= IDLE;
      req     <= '0;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      regs    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Only a proper setup cycle starts a transfer. An access phase
          // with no preceding setup cycle is ignored.
          if (psel && !penable) begin
            req   <= '{addr: paddr, write: pwrite, wdata: pwdata};
            cnt   <= 4'(WAIT_STATES);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!psel) begin
            state <= IDLE;                 // master abandoned the transfer
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state   <= READY;
            pready  <= 1'b1;
            pslverr <= err;
            prdata  <= (!req.write && !err) ? regs[ridx] : '0;
          end
        end
        READY: begin
          // The write lands on the completing edge. A following read of
          // the same register therefore returns the new value.
          if (req.write && !err && psel && penable)
            regs[ridx] <= req.wdata;
          state   <= IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int WS     = 1;
  localparam int WPL    = 4;
  localparam int TMO    = 40;

`ifdef APB_SLV_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;

  always #5 pclk = ~pclk;

  apb_slave_regfile #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_STATES(WS), .WPROT_LIMIT(WPL)
  ) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [DEPTH];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic wr, input logic [31:0] a);
    int unsigned idx;
    idx = int'(a[31:2]);
    return (a[1:0] != 2'b00) || (idx >= DEPTH) || (WPROT && wr && idx < WPL);
  endfunction

  task automatic clr_model();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  // One complete transfer. The expected response is queued before the
  // transfer is driven and popped when pready appears.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input string tag);
    exp_t e;
    int   cyc;
    logic er;
    er      = model_err(wr, a);
    e.err   = er;
    e.rdata = (!wr && !er) ? mdl[a[5:2]] : 32'h0;
    sbq.push_back(e);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1; paddr = a ^ 32'h4; pwdata = ~d;   // should be ignored
    cyc = 1;
    @(negedge pclk);
    while (pready !== 1'b1 && cyc < TMO) begin
      @(posedge pclk); #1; cyc++;
      @(negedge pclk);
    end
    chk({tag, " latency"}, 32'(cyc), 32'(WS + 2));
    e = sbq.pop_front();
    chk({tag, " prdata"}, prdata, e.rdata);
    chk({tag, " pslverr"}, {31'b0, pslverr}, {31'b0, e.err});
    if (wr && !er) mdl[a[5:2]] = d;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk({tag, " pready_drop"}, {31'b0, pready}, 32'h0);
  endtask

  initial begin
    clr_model();
    // Reset held for two edges.
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("reset pready", {31'b0, pready}, 32'h0);
    chk("reset pslverr", {31'b0, pslverr}, 32'h0);
    chk("reset prdata", prdata, 32'h0);
    @(posedge pclk); #1; preset = 1'b0;

    xfer(1'b0, 32'h14, 32'h0, "rd5_after_reset");
    xfer(1'b1, 32'h14, 32'hDEADBEEF, "wr14");
    xfer(1'b0, 32'h14, 32'h0, "rd14");

    // Error cases: misaligned, index == DEPTH, upper address bit set.
    xfer(1'b0, 32'h13, 32'h0, "rd_misaligned");
    xfer(1'b1, 32'h40, 32'hFFFFFFFF, "wr_oor");
    xfer(1'b0, 32'h00, 32'h0, "rd0_no_alias");
    xfer(1'b1, 32'h8000_0030, 32'h0BADF00D, "wr_upper_bit");
    xfer(1'b0, 32'h30, 32'h0, "rd30_unchanged");

    // Last register.
    xfer(1'b1, 32'h3C, 32'hA5A55A5A, "wr3c");
    xfer(1'b0, 32'h3C, 32'h0, "rd3c");

    // psel dropped in WAIT: no completion and no write.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hCAFEF00D;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("abort pready_low", {31'b0, pready}, 32'h0);
    end
    xfer(1'b0, 32'h08, 32'h0, "rd8_after_abort");

    // Reset asserted in WAIT of a write.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h11112222;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; preset = 1'b1;
    @(posedge pclk); #1; preset = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("midreset pready", {31'b0, pready}, 32'h0);
    chk("midreset pslverr", {31'b0, pslverr}, 32'h0);
    chk("midreset prdata", prdata, 32'h0);
    clr_model();
    xfer(1'b0, 32'h14, 32'h0, "rd14_cleared");
    xfer(1'b0, 32'h0C, 32'h0, "rdc_discarded");
    xfer(1'b1, 32'h0C, 32'h11112222, "wrc_after_reset");
    xfer(1'b0, 32'h0C, 32'h0, "rdc_after_reset");

    // Low register: protected only when the feature is built in.
    xfer(1'b1, 32'h04, 32'h00001234, "wr4");
    xfer(1'b0, 32'h04, 32'h0, "rd4");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
